// File: rtl/pc_update_unit.sv
// pc_update_unit: PC register with exception vectoring; define PC_BRANCH_COUNT_EN to add the taken-branch counter.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_BASE = 32'h0000_00F0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        MuxPCWriteCondFio,
    input  logic [2:0]  PCSource,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    input  logic [25:0] JumpTarget,
    input  logic        Exception,
    input  logic [1:0]  ExcCause,
    output logic [31:0] PC,
    output logic [31:0] EPC,
    output logic [1:0]  Cause,
    output logic        ExcBusy,
    output logic        PCLoaded,
    output logic        BranchTaken,
    output logic        PCMisaligned,
    output logic [15:0] BranchCount
);
    typedef enum logic {RUN, EXC_VEC} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, epc_q, epc_d, next_pc;
    logic [1:0]  cause_q, cause_d;
    logic        loaded_q, loaded_d, taken_q, taken_d, mis_q, mis_d, wr_en;
    always_comb begin
        wr_en   = PCWrite | (PCWriteCond & MuxPCWriteCondFio);
        next_pc = (PCSource[1:0] == 2'd0) ? ALUResult :
                  (PCSource[1:0] == 2'd1) ? ALUOut :
                  (PCSource[1:0] == 2'd2) ? {pc_q[31:28], JumpTarget, 2'b00} : epc_q;
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        loaded_d = 1'b0;
        taken_d  = 1'b0;
        mis_d    = mis_q;
        if (state_q == EXC_VEC) begin
            pc_d     = EXC_BASE + {28'b0, cause_q, 2'b00};
            loaded_d = 1'b1;
            state_d  = RUN;
        end else if (Exception) begin
            epc_d   = pc_q - 32'd4;
            cause_d = ExcCause;
            state_d = EXC_VEC;
        end else if (wr_en && !PCSource[2]) begin
            pc_d     = next_pc;
            loaded_d = 1'b1;
            taken_d  = ~PCWrite;
            mis_d    = mis_q | (|next_pc[1:0]);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            epc_q    <= '0;
            cause_q  <= '0;
            loaded_q <= 1'b0;
            taken_q  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            loaded_q <= loaded_d;
            taken_q  <= taken_d;
            mis_q    <= mis_d;
        end
    end
`ifdef PC_BRANCH_COUNT_EN
    logic [15:0] bc_q, bc_d;
    always_comb bc_d = (taken_d && bc_q != 16'hFFFF) ? bc_q + 16'd1 : bc_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bc_q <= '0;
        else bc_q <= bc_d;
    end
    assign BranchCount = bc_q;
`else
    assign BranchCount = 16'h0000;
`endif
    assign PC           = pc_q;
    assign EPC          = epc_q;
    assign Cause        = cause_q;
    assign ExcBusy      = (state_q == EXC_VEC);
    assign PCLoaded     = loaded_q;
    assign BranchTaken  = taken_q;
    assign PCMisaligned = mis_q;
endmodule
